// File: rtl/alu_pkg.sv
// Shared definitions for the iterative MIPS-style ALU: funct codes, FSM states,
// and the decode that separates multi-cycle multiply/divide from single-cycle ops.
package alu_pkg;

  localparam logic [5:0] OP_NOP   = 6'b000000;
  localparam logic [5:0] OP_ADD   = 6'b100000;
  localparam logic [5:0] OP_ADDU  = 6'b100001;
  localparam logic [5:0] OP_SUB   = 6'b100010;
  localparam logic [5:0] OP_SUBU  = 6'b100011;
  localparam logic [5:0] OP_AND   = 6'b100100;
  localparam logic [5:0] OP_OR    = 6'b100101;
  localparam logic [5:0] OP_XOR   = 6'b100110;
  localparam logic [5:0] OP_NOR   = 6'b100111;
  localparam logic [5:0] OP_SLT   = 6'b101010;
  localparam logic [5:0] OP_SLTU  = 6'b101011;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic is_muldiv(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative multiply/divide datapath on operand magnitudes: one bit per step,
// signs restored by fix. Owns the architectural HI/LO registers (written on fix only).
module md_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             fix_i,
  input  logic             is_div_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] lo_fix_o
);

  logic [WIDTH-1:0]   acc_q, acc_d, sh_q, sh_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic               div_q, div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
  logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix, hi_fix;
  logic [WIDTH:0]     add_sum, shifted;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign a_mag = (is_signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag = (is_signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

  // Multiply: acc:sh is the running product with the multiplier shifting out of sh.
  // Divide: sh holds the dividend shifting into acc (partial remainder), quotient bits fill sh.
  assign add_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, m_q} : '0);
  assign shifted = {acc_q, sh_q[WIDTH-1]};

  assign prod     = {acc_q, sh_q};
  assign prod_fix = neg_res_q ? -prod : prod;
  // With a zero divisor every trial subtract succeeds, so acc ends up as |a|
  // and the remainder sign fix restores the original dividend.
  assign quo_fix  = dz_q ? '1 : (neg_res_q ? -sh_q : sh_q);
  assign rem_fix  = neg_rem_q ? -acc_q : acc_q;
  assign hi_fix   = div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign lo_fix_o = div_q ? quo_fix : prod_fix[WIDTH-1:0];

  always_comb begin
    acc_d     = acc_q;
    sh_d      = sh_q;
    m_d       = m_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    if (load_i) begin
      div_d     = is_div_i;
      neg_res_d = is_signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      neg_rem_d = is_signed_i & a_i[WIDTH-1];
      dz_d      = is_div_i && (b_i == '0);
      acc_d     = '0;
      sh_d      = is_div_i ? a_mag : b_mag;
      m_d       = is_div_i ? b_mag : a_mag;
    end else if (step_i) begin
      if (div_q) begin
        if (shifted >= {1'b0, m_q}) begin
          acc_d = shifted[WIDTH-1:0] - m_q;
          sh_d  = {sh_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shifted[WIDTH-1:0];
          sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = add_sum[WIDTH:1];
        sh_d  = {add_sum[0], sh_q[WIDTH-1:1]};
      end
    end else if (fix_i) begin
      hi_d = hi_fix;
      lo_d = lo_fix_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      sh_q      <= '0;
      m_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      sh_q      <= sh_d;
      m_q       <= m_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/alu_iter.sv
// Iterative MIPS-funct ALU: single-cycle ops finish one cycle after accept,
// mul/div after WIDTH+2 cycles; start is only accepted in IDLE, never queued.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       alu_op,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d, ovf_q, ovf_d;
  logic             md_load, md_step, md_fix;
  logic [WIDTH-1:0] md_lo_fix, sum, dif, sc_res;
  logic             sc_ovf;

  assign sum = alu_a + alu_b;
  assign dif = alu_a - alu_b;

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (alu_op)
      OP_NOP:  sc_res = '0;
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_a[WIDTH-1]);
      end
      OP_ADDU: sc_res = sum;
      OP_SUB: begin
        sc_res = dif;
        sc_ovf = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (dif[WIDTH-1] != alu_a[WIDTH-1]);
      end
      OP_SUBU: sc_res = dif;
      OP_AND:  sc_res = alu_a & alu_b;
      OP_OR:   sc_res = alu_a | alu_b;
      OP_XOR:  sc_res = alu_a ^ alu_b;
      OP_NOR:  sc_res = ~(alu_a | alu_b);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, alu_a < alu_b};
      OP_MFHI: sc_res = hi;
      OP_MFLO: sc_res = lo;
      default: sc_res = '0;
    endcase
  end

  md_unit #(.WIDTH(WIDTH)) u_md (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (md_load),
    .step_i     (md_step),
    .fix_i      (md_fix),
    .is_div_i   ((alu_op == OP_DIV) || (alu_op == OP_DIVU)),
    .is_signed_i((alu_op == OP_MULT) || (alu_op == OP_DIV)),
    .a_i        (alu_a),
    .b_i        (alu_b),
    .hi_o       (hi),
    .lo_o       (lo),
    .lo_fix_o   (md_lo_fix)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    md_load = 1'b0;
    md_step = 1'b0;
    md_fix  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_muldiv(alu_op)) begin
            md_load = 1'b1;
            cnt_d   = '0;
            state_d = S_EXEC;
          end else begin
            out_d   = sc_res;
            zero_d  = (sc_res == '0);
            ovf_d   = sc_ovf;
            state_d = S_DONE;
          end
        end
      end
      S_EXEC: begin
        md_step = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        md_fix  = 1'b1;
        out_d   = md_lo_fix;
        zero_d  = (md_lo_fix == '0);
        ovf_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == S_EXEC) || (state_q == S_FIX);
  assign done     = (state_q == S_DONE);
  assign alu_out  = out_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter at WIDTH=32 and WIDTH=8 with hand-computed results,
// latencies measured in cycles from the accepting edge.
module tb_alu_iter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start32 = 1'b0, start8 = 1'b0;
  logic [5:0]  op32 = '0, op8 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy32, done32, zero32, ovf32;
  logic        busy8, done8, zero8, ovf8;
  logic [31:0] out32, hi32, lo32;
  logic [7:0]  out8, hi8, lo8;

  int total = 0;
  int bad = 0;
  int lat, bb;
  logic [31:0] ro;
  logic        rz, rv;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        v;
  } vec_t;
  vec_t vecs [13];

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .alu_op(op32), .alu_a(a32), .alu_b(b32),
    .busy(busy32), .done(done32), .alu_out(out32), .zero(zero32), .overflow(ovf32),
    .hi(hi32), .lo(lo32)
  );

  alu_iter #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .alu_op(op8), .alu_a(a8), .alu_b(b8),
    .busy(busy8), .done(done8), .alu_out(out8), .zero(zero8), .overflow(ovf8),
    .hi(hi8), .lo(lo8)
  );

  // Called 1 time unit after a rising edge with the DUT idle; returns the done-cycle
  // outputs, latency from the accepting edge, and how often busy disagreed.
  task automatic run32(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    start32 = 1'b1; op32 = op; a32 = a; b32 = b;
    @(posedge clk); #1;
    start32 = 1'b0; a32 = ~a; b32 = ~b; op32 = OP_ADD;
    lat = 1; bb = 0;
    while (done32 !== 1'b1 && lat < 100) begin
      if (busy32 !== 1'b1) bb++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy32 !== 1'b0) bb++;
    ro = out32; rz = zero32; rv = ovf32;
    @(posedge clk); #1;
  endtask

  task automatic run8(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    start8 = 1'b1; op8 = op; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~a; b8 = ~b; op8 = OP_ADD;
    lat = 1; bb = 0;
    while (done8 !== 1'b1 && lat < 100) begin
      if (busy8 !== 1'b1) bb++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy8 !== 1'b0) bb++;
    ro = {24'h0, out8}; rz = zero8; rv = ovf8;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    total++; if ({busy32, done32, zero32, ovf32} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {busy32, done32, zero32, ovf32}); end
    total++; if (out32 !== 32'h0) begin bad++; $display("FAIL reset_out got=%h want=0", out32); end
    total++; if ({hi32, lo32} !== 64'h0) begin bad++; $display("FAIL reset_hilo got=%h want=0", {hi32, lo32}); end
    total++; if ({busy8, done8, out8, hi8, lo8} !== 26'h0) begin bad++; $display("FAIL reset_w8 got=%h want=0", {busy8, done8, out8, hi8, lo8}); end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_overflow();
    run32(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    total++; if (lat != 1) begin bad++; $display("FAIL add_latency got=%0d want=1", lat); end
    total++; if (ro !== 32'h8000_0000) begin bad++; $display("FAIL add_out got=%h want=80000000", ro); end
    total++; if ({rv, rz} !== 2'b10) begin bad++; $display("FAIL add_ovf_zero got=%b want=10", {rv, rz}); end
    run32(OP_ADDU, 32'h7FFF_FFFF, 32'h0000_0001);
    total++; if (ro !== 32'h8000_0000 || rv !== 1'b0) begin bad++; $display("FAIL addu got=%h/%b want=80000000/0", ro, rv); end
  endtask

  task automatic test_single_cycle();
    vecs = '{
      '{OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0},
      '{OP_OR,   32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1'b0},
      '{OP_XOR,  32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 1'b0},
      '{OP_NOR,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h000F_00CB, 1'b0},
      '{OP_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0},
      '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0},
      '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0},
      '{OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1},
      '{OP_SUBU, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0},
      '{OP_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0},
      '{OP_ADD,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0},
      '{OP_SUB,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1},
      '{OP_NOP,  32'h1234_5678, 32'h0000_0009, 32'h0000_0000, 1'b0}
    };
    for (int i = 0; i < 13; i++) begin
      run32(vecs[i].op, vecs[i].a, vecs[i].b);
      total++;
      if (lat != 1 || ro !== vecs[i].r || rv !== vecs[i].v || rz !== (vecs[i].r == 32'h0)) begin
        bad++;
        $display("FAIL single_%0d got=%h ovf=%b zero=%b lat=%0d want=%h ovf=%b lat=1",
                 i, ro, rv, rz, lat, vecs[i].r, vecs[i].v);
      end
    end
    total++; if ({hi32, lo32} !== 64'h0) begin bad++; $display("FAIL hilo_untouched got=%h want=0", {hi32, lo32}); end
  endtask

  task automatic test_mult();
    run32(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
    total++; if (lat != 34) begin bad++; $display("FAIL mult_latency got=%0d want=34", lat); end
    total++; if (bb != 0) begin bad++; $display("FAIL mult_busy got=%0d want=0 bad cycles", bb); end
    total++; if (hi32 !== 32'hFFFF_FFFF || lo32 !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_hilo got=%h_%h want=ffffffff_ffffffeb", hi32, lo32); end
    total++; if (ro !== 32'hFFFF_FFEB || rv !== 1'b0) begin bad++; $display("FAIL mult_out got=%h/%b want=ffffffeb/0", ro, rv); end
  endtask

  task automatic test_div();
    run32(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    total++; if (lo32 !== 32'hFFFF_FFFD || hi32 !== 32'hFFFF_FFFF || ro !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg got=%h_%h want=ffffffff_fffffffd", hi32, lo32); end
    run32(OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE);
    total++; if (lo32 !== 32'hFFFF_FFFD || hi32 !== 32'h0000_0001) begin bad++; $display("FAIL div_negdivisor got=%h_%h want=00000001_fffffffd", hi32, lo32); end
    run32(OP_DIVU, 32'h0000_0064, 32'h0000_0007);
    total++; if (lo32 !== 32'h0000_000E || hi32 !== 32'h0000_0002) begin bad++; $display("FAIL divu got=%h_%h want=00000002_0000000e", hi32, lo32); end
    run32(OP_DIVU, 32'h0000_0007, 32'h0000_0000);
    total++; if (lat != 34 || lo32 !== 32'hFFFF_FFFF || hi32 !== 32'h0000_0007) begin bad++; $display("FAIL divu_by0 got=%h_%h lat=%0d want=00000007_ffffffff lat=34", hi32, lo32, lat); end
    run32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    total++; if (lo32 !== 32'h8000_0000 || hi32 !== 32'h0 || rv !== 1'b0) begin bad++; $display("FAIL div_minneg got=%h_%h ovf=%b want=00000000_80000000 ovf=0", hi32, lo32, rv); end
    run32(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0000);
    total++; if (lo32 !== 32'hFFFF_FFFF || hi32 !== 32'hFFFF_FFF9) begin bad++; $display("FAIL div_by0_signed got=%h_%h want=fffffff9_ffffffff", hi32, lo32); end
  endtask

  task automatic test_unknown_and_mf();
    run32(6'b111111, 32'h1234_5678, 32'h9ABC_DEF0);
    total++; if (lat != 1 || ro !== 32'h0 || rz !== 1'b1 || rv !== 1'b0) begin bad++; $display("FAIL unknown got=%h zero=%b ovf=%b lat=%0d want=0 zero=1 ovf=0 lat=1", ro, rz, rv, lat); end
    total++; if (hi32 !== 32'hFFFF_FFF9 || lo32 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL unknown_hilo got=%h_%h want=fffffff9_ffffffff", hi32, lo32); end
    run32(OP_MFHI, 32'h0, 32'h0);
    total++; if (ro !== 32'hFFFF_FFF9 || lat != 1) begin bad++; $display("FAIL mfhi got=%h want=fffffff9", ro); end
    run32(OP_MFLO, 32'h0, 32'h0);
    total++; if (ro !== 32'hFFFF_FFFF || rz !== 1'b0) begin bad++; $display("FAIL mflo got=%h want=ffffffff", ro); end
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    int first = 0;
    start32 = 1'b1; op32 = OP_MULTU; a32 = 32'h0001_0000; b32 = 32'h0003_0003;
    @(posedge clk); #1;
    for (int c = 1; c <= 45; c++) begin
      if (done32 === 1'b1) begin
        ndone++;
        if (first == 0) first = c;
      end
      if (first != 0 && c > first) begin
        start32 = 1'b0;
      end else begin
        op32 = (c % 2 == 0) ? OP_ADD : OP_MULT;
        a32  = $urandom;
        b32  = $urandom;
      end
      @(posedge clk); #1;
    end
    start32 = 1'b0;
    total++; if (ndone != 1 || first != 34) begin bad++; $display("FAIL b2b_done got=%0d pulses first=%0d want=1 pulse at 34", ndone, first); end
    total++; if (hi32 !== 32'h0000_0003 || lo32 !== 32'h0003_0000) begin bad++; $display("FAIL b2b_hilo got=%h_%h want=00000003_00030000", hi32, lo32); end
    run32(OP_MFLO, 32'h0, 32'h0);
    total++; if (ro !== 32'h0003_0000) begin bad++; $display("FAIL b2b_mflo got=%h want=00030000", ro); end
  endtask

  task automatic test_reset_mid();
    int nd = 0;
    start32 = 1'b1; op32 = OP_DIV; a32 = 32'hFFFF_FFF9; b32 = 32'h0000_0002;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({busy32, done32, zero32, ovf32} !== 4'b0 || out32 !== 32'h0) begin bad++; $display("FAIL midrst_out got=%b/%h want=0000/0", {busy32, done32, zero32, ovf32}, out32); end
    total++; if ({hi32, lo32} !== 64'h0) begin bad++; $display("FAIL midrst_hilo got=%h want=0", {hi32, lo32}); end
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; if (done32 === 1'b1) nd++; end
    total++; if (nd != 0 || {hi32, lo32} !== 64'h0) begin bad++; $display("FAIL midrst_nodone got=%0d done hilo=%h want=0 done hilo=0", nd, {hi32, lo32}); end
    run32(OP_SUB, 32'h5, 32'h5);
    total++; if (lat != 1 || ro !== 32'h0 || rz !== 1'b1 || rv !== 1'b0) begin bad++; $display("FAIL midrst_sub got=%h zero=%b lat=%0d want=0 zero=1 lat=1", ro, rz, lat); end
  endtask

  task automatic test_width8();
    run8(OP_MULT, 8'hFD, 8'h07);
    total++; if (lat != 10 || bb != 0) begin bad++; $display("FAIL w8_mult_latency got=%0d busybad=%0d want=10/0", lat, bb); end
    total++; if (hi8 !== 8'hFF || lo8 !== 8'hEB || ro !== 32'hEB) begin bad++; $display("FAIL w8_mult got=%h_%h want=ff_eb", hi8, lo8); end
    run8(OP_MULTU, 8'hFF, 8'hFF);
    total++; if (hi8 !== 8'hFE || lo8 !== 8'h01) begin bad++; $display("FAIL w8_multu got=%h_%h want=fe_01", hi8, lo8); end
    run8(OP_DIV, 8'h80, 8'hFF);
    total++; if (hi8 !== 8'h00 || lo8 !== 8'h80 || rv !== 1'b0) begin bad++; $display("FAIL w8_div_minneg got=%h_%h want=00_80", hi8, lo8); end
    run8(OP_ADD, 8'h7F, 8'h01);
    total++; if (lat != 1 || ro !== 32'h80 || rv !== 1'b1) begin bad++; $display("FAIL w8_add got=%h ovf=%b lat=%0d want=80 ovf=1 lat=1", ro, rv, lat); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_single_cycle();
    test_mult();
    test_div();
    test_unknown_and_mf();
    test_back_to_back();
    test_reset_mid();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 8..64.
REQ-002 clk  input  1  rising-edge system clock; single clock domain.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request; accepted only when busy=0.
REQ-005 alu_op  input  6  MIPS funct code, sampled on accept.
REQ-006 alu_a  input  WIDTH  operand A, sampled on accept.
REQ-007 alu_b  input  WIDTH  operand B, sampled on accept.
REQ-008 busy  output  1  high from the cycle after accept until done.
REQ-009 done  output  1  one-cycle pulse; alu_out/zero/overflow are valid in this cycle.
REQ-010 alu_out  output  WIDTH  registered result, held until the next done.
REQ-011 zero  output  1  registered (alu_out == 0).
REQ-012 overflow  output  1  registered signed-overflow flag (ADD/SUB only).
REQ-013 hi, lo  output  WIDTH each  HI/LO registers written only by MULT/MULTU/DIV/DIVU.

Function
REQ-014 Ops: NOP 000000, ADD 100000, ADDU 100001, SUB 100010, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011, MFHI 010000, MFLO 010010, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
REQ-015 FSM states: IDLE, EXEC, FIX, DONE; IDLE->DONE for single-cycle ops, IDLE->EXEC->FIX->DONE for mul/div, DONE->IDLE unconditionally.
REQ-016 Single-cycle ops (incl. NOP, MFHI, MFLO, unknown codes): done asserted in cycle N+1 for accept in cycle N.
REQ-017 Mul/div: EXEC runs exactly WIDTH cycles (shift-add / restoring divide, one bit per cycle), FIX one cycle of sign correction; done in cycle N+WIDTH+2.
REQ-018 start while busy=1 or in the done cycle is ignored; no queuing.
REQ-019 ADD/SUB/ADDU/SUBU wrap modulo 2^WIDTH; overflow=1 only for ADD/SUB signed overflow, else 0; result still written on overflow.
REQ-020 SLT signed, SLTU unsigned compare; alu_out = {0..0,result bit}.
REQ-021 MULT/MULTU: {hi,lo} = full 2*WIDTH product, signed or unsigned per op; alu_out = lo.
REQ-022 DIV/DIVU: lo = quotient truncated toward zero, hi = remainder with sign of dividend; alu_out = lo.
REQ-023 Divide by zero: no trap, same latency, lo = all ones, hi = alu_a.
REQ-024 DIV of most-negative by -1: lo = most-negative value, hi = 0, no flag.
REQ-025 Unknown alu_op: alu_out = 0, zero=1, overflow=0, hi/lo unchanged.
REQ-026 MFHI/MFLO return hi/lo as they stand at accept.
REQ-027 Operands are captured on accept; input changes during busy have no effect.

Reset
REQ-028 rst_n low asynchronously forces state IDLE and busy, done, alu_out, zero, overflow, hi, lo, all internal iteration registers to 0.
REQ-029 Reset mid-operation aborts the operation with no done pulse and no hi/lo update; first start after release behaves normally.

Structure
REQ-030 Package alu_pkg holds the funct-code constants, the state enumeration, and an is_muldiv helper.
REQ-031 One sub-module md_unit (iterative multiply/divide datapath, WIDTH-parametrised, load/step/fix controls from the parent FSM); logic ops and compare remain in alu_iter.

Verification
REQ-032 WIDTH=32, ADD 0x7FFFFFFF+1 -> done at N+1, alu_out=0x80000000, overflow=1, zero=0; ADDU same operands -> overflow=0.
REQ-033 MULT -3 x 7 -> done at N+34, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy high cycles N+1..N+33.
REQ-034 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> lo=0xFFFFFFFF, hi=7, done at N+34.
REQ-035 start pulsed every cycle during a MULTU -> exactly one done; following MFLO returns the product low word.
REQ-036 rst_n asserted at cycle N+10 of a DIV -> outputs 0 immediately, no done; SUB 5-5 after release -> alu_out=0, zero=1.
REQ-037 Unknown op 111111 -> done at N+1, alu_out=0, zero=1, hi/lo unchanged; repeat REQ-033 with WIDTH=8 (-3x7 -> hi=0xFF, lo=0xEB, done at N+10).
